csa10_accumulator: RTL and testbench

Sequential accumulation stage around the team's 10-bit carry-select adder `csa_10bit`. The block accepts a programmed number of 10-bit terms over a valid/ready stream, one per cycle. Each term is fed into `csa_10bit` together with the running accumulator. The block captures the adder's sum and carry-out back into registers. It delivers the final sum and a count of carry-outs (wrap events) on a valid/ready result port, sitting between an operand source and a result consumer.

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_10bit.sv | 45 ++++
 rtl/csa10_accumulator.sv | 150 +++++++++++++++
 tb/tb_csa10_accumulator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-select accumulation slice.
// Contents:
//   acc_state_t : accumulator controller states (IDLE, ACCUM, DONE), 2-bit encoded
//   CSA_WIDTH   : operand width of the csa_10bit adder
package csa_pkg;

    localparam int CSA_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } acc_state_t;

endpackage : csa_pkg

// File: rtl/csa_10bit.sv
// 10-bit carry-select adder.
// The lower half ripples normally; the upper half is computed twice
// (carry-in 0 and carry-in 1) and the lower half's carry-out selects
// the correct upper result.
// Ports:
//   a, b : CSA_WIDTH-bit operands
//   cin  : carry in
//   sum  : CSA_WIDTH-bit sum
//   cout : carry out of the top bit
module csa_10bit
    import csa_pkg::*;
(
    input  logic [CSA_WIDTH-1:0] a,
    input  logic [CSA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [CSA_WIDTH-1:0] sum,
    output logic                 cout
);

    localparam int LO_W = CSA_WIDTH / 2;
    localparam int HI_W = CSA_WIDTH - LO_W;

    logic [LO_W:0] lo_s;
    logic [HI_W:0] hi0_s;
    logic [HI_W:0] hi1_s;

    assign lo_s  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]} + {{LO_W{1'b0}}, cin};
    assign hi0_s = {1'b0, a[CSA_WIDTH-1:LO_W]} + {1'b0, b[CSA_WIDTH-1:LO_W]};
    assign hi1_s = {1'b0, a[CSA_WIDTH-1:LO_W]} + {1'b0, b[CSA_WIDTH-1:LO_W]}
                   + {{HI_W{1'b0}}, 1'b1};

    // Select the precomputed upper half using the lower-half carry.
    always_comb begin
        sum  = {CSA_WIDTH{1'b0}};
        cout = 1'b0;
        if (lo_s[LO_W]) begin
            sum  = {hi1_s[HI_W-1:0], lo_s[LO_W-1:0]};
            cout = hi1_s[HI_W];
        end else begin
            sum  = {hi0_s[HI_W-1:0], lo_s[LO_W-1:0]};
            cout = hi0_s[HI_W];
        end
    end

endmodule : csa_10bit

// File: rtl/csa10_accumulator.sv
// Sequential accumulator around csa_10bit.
// After i_start (with length i_len) the block accepts i_len terms over a
// valid/ready stream, adds each into a running accumulator and counts adder
// carry-outs (saturating). The result is then offered on a valid/ready port.
// Ports:
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_start, i_len       : start pulse and term count (sampled in IDLE only)
//   i_valid, o_ready,
//   i_data               : term stream
//   o_valid, i_ready     : result handshake
//   o_sum, o_ovf_cnt     : accumulated sum mod 2^WIDTH, saturating carry count
//   o_busy               : controller not in IDLE
module csa10_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int COUNT_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_len,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_sum,
    output logic [COUNT_W-1:0] o_ovf_cnt,
    output logic               o_busy
);

    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

    acc_state_t         state_r;
    acc_state_t         state_nx_s;
    logic [WIDTH-1:0]   acc_r;
    logic [COUNT_W-1:0] cnt_r;
    logic [COUNT_W-1:0] rem_r;
    logic [WIDTH-1:0]   add_sum_s;
    logic               add_cout_s;
    logic               accept_s;

    // Saturating increment of the carry counter.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    csa_10bit u_adder (
        .a    (acc_r),
        .b    (i_data),
        .cin  (1'b0),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    assign accept_s = (state_r == ACCUM) && i_valid;

    // Next-state decode for the controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    if (i_len == CNT_ZERO) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = ACCUM;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && (rem_r == CNT_ONE)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = ACCUM;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Accumulator, carry count and remaining-term registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r <= {WIDTH{1'b0}};
            cnt_r <= CNT_ZERO;
            rem_r <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        acc_r <= {WIDTH{1'b0}};
                        cnt_r <= CNT_ZERO;
                        rem_r <= i_len;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_r <= add_sum_s;
                        rem_r <= rem_r - CNT_ONE;
                        if (add_cout_s) begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                end
                DONE: begin
                    // Result held stable until the consumer takes it.
                end
                default: begin
                    acc_r <= {WIDTH{1'b0}};
                    cnt_r <= CNT_ZERO;
                    rem_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Handshake and status outputs decode only from registered state.
    assign o_ready   = (state_r == ACCUM);
    assign o_valid   = (state_r == DONE);
    assign o_busy    = (state_r != IDLE);
    assign o_sum     = acc_r;
    assign o_ovf_cnt = cnt_r;

endmodule : csa10_accumulator

// File: tb/tb_csa10_accumulator.sv
// Directed testbench for csa10_accumulator with an integer-level reference
// model and a per-cycle output comparison.
module tb_csa10_accumulator;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_start;
    logic [3:0] i_len;
    logic       i_valid;
    logic       o_ready;
    logic [9:0] i_data;
    logic       o_valid;
    logic       i_ready;
    logic [9:0] o_sum;
    logic [3:0] o_ovf_cnt;
    logic       o_busy;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = idle, 1 = collecting terms, 2 = result offered
    int m_mode, m_left, m_sum, m_ovf;
    int nx_mode, nx_left, nx_sum, nx_ovf, total;

    csa10_accumulator #(.WIDTH(10), .COUNT_W(4)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_len     (i_len),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_ovf_cnt (o_ovf_cnt),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model next values: plain integer arithmetic on the sum, wrap at 1024.
    always_comb begin
        nx_mode = m_mode;
        nx_left = m_left;
        nx_sum  = m_sum;
        nx_ovf  = m_ovf;
        total   = 0;
        case (m_mode)
            0: if (i_start) begin
                nx_sum  = 0;
                nx_ovf  = 0;
                nx_left = int'(i_len);
                nx_mode = (i_len == 4'd0) ? 2 : 1;
            end
            1: if (i_valid) begin
                total   = m_sum + int'(i_data);
                nx_sum  = total % 1024;
                if (total >= 1024 && m_ovf < 15) nx_ovf = m_ovf + 1;
                nx_left = m_left - 1;
                if (m_left == 1) nx_mode = 2;
            end
            2: if (i_ready) nx_mode = 0;
            default: nx_mode = 0;
        endcase
    end

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_mode <= 0;
            m_left <= 0;
            m_sum  <= 0;
            m_ovf  <= 0;
        end else begin
            m_mode <= nx_mode;
            m_left <= nx_left;
            m_sum  <= nx_sum;
            m_ovf  <= nx_ovf;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        check("cyc_ready", int'(o_ready), int'(m_mode == 1));
        check("cyc_valid", int'(o_valid), int'(m_mode == 2));
        check("cyc_busy",  int'(o_busy),  int'(m_mode != 0));
        check("cyc_sum",   int'(o_sum),   m_sum);
        check("cyc_ovf",   int'(o_ovf_cnt), m_ovf);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start(input int len);
        i_start = 1'b1;
        i_len   = 4'(len);
        tick();
        i_start = 1'b0;
        i_len   = 4'd0;
    endtask

    task automatic send(input int d);
        i_valid = 1'b1;
        i_data  = 10'(d);
        tick();
        i_valid = 1'b0;
        i_data  = 10'd0;
    endtask

    task automatic wait_result();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check("result_timeout", 0, 1);
    endtask

    task automatic consume();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_len   = 4'd0;
        i_valid = 1'b0;
        i_data  = 10'd0;
        i_ready = 1'b0;
        tick();
        tick();
        check("rst_busy",  int'(o_busy), 0);
        check("rst_sum",   int'(o_sum), 0);
        check("rst_valid", int'(o_valid), 0);
        i_rst_n = 1'b1;
        tick();

        // Basic sum: 100+200+300, result one cycle after the last term
        start(3);
        check("basic_ready", int'(o_ready), 1);
        send(100);
        send(200);
        send(300);
        check("basic_latency", int'(o_valid), 1);
        check("basic_sum", int'(o_sum), 600);
        check("basic_ovf", int'(o_ovf_cnt), 0);
        consume();
        check("basic_idle", int'(o_busy), 0);

        // Wrap: four terms of 1000 -> 4000 mod 1024 = 928 with 3 carries
        start(4);
        for (int i = 0; i < 4; i++) send(1000);
        wait_result();
        check("wrap_sum", int'(o_sum), 928);
        check("wrap_ovf", int'(o_ovf_cnt), 3);
        consume();

        // Zero length goes straight to the result
        start(0);
        check("zero_valid", int'(o_valid), 1);
        check("zero_ready", int'(o_ready), 0);
        check("zero_sum", int'(o_sum), 0);
        check("zero_ovf", int'(o_ovf_cnt), 0);
        consume();

        // Gaps between terms
        start(2);
        send(5);
        tick();
        tick();
        tick();
        check("gap_ready", int'(o_ready), 1);
        send(7);
        wait_result();
        check("gap_sum", int'(o_sum), 12);

        consume();

        // Backpressure in DONE and an ignored start: 600+500 = 1100 -> 76, 1 carry
        start(2);
        send(600);
        send(500);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(o_valid), 1);
            check("bp_sum", int'(o_sum), 76);
            check("bp_ovf", int'(o_ovf_cnt), 1);
            tick();
        end
        start(3);
        check("ign_valid", int'(o_valid), 1);
        check("ign_ready", int'(o_ready), 0);
        check("ign_sum", int'(o_sum), 76);
        consume();
        check("bp_idle_busy", int'(o_busy), 0);
        check("bp_idle_valid", int'(o_valid), 0);

        // Reset mid-accumulation
        start(5);
        send(40);
        send(50);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", int'(o_ready), 0);
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_sum", int'(o_sum), 0);
        check("mid_rst_ovf", int'(o_ovf_cnt), 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        start(1);
        send(9);
        check("after_rst_valid", int'(o_valid), 1);
        check("after_rst_sum", int'(o_sum), 9);
        check("after_rst_ovf", int'(o_ovf_cnt), 0);
        consume();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_csa10_accumulator
